// File: rtl/cpu_run_ctrl.sv
// Run/halt/single-step controller for the Basys3 simple CPU: debounced buttons,
// instruction-granular clock-enable sequencing and a PC breakpoint.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_HALT  | CPU frozen (cpu_en=0), waiting for a run or step press
// ST_RUN   | CPU free-running; halts/breaks only on instr_done
// ST_STEP  | CPU enabled until exactly one instruction retires
// ST_BREAK | CPU frozen after retiring the instruction at bp_addr
module cpu_run_ctrl #(
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int PC_WIDTH        = 8,
   parameter int CNT_WIDTH       = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 btn_run,
   input  logic                 btn_step,
   input  logic                 bp_en,
   input  logic [PC_WIDTH-1:0]  bp_addr,
   input  logic [PC_WIDTH-1:0]  pc,
   input  logic                 instr_done,
   output logic                 cpu_en,
   output logic [1:0]           state,
   output logic                 halted,
   output logic [CNT_WIDTH-1:0] retired
);

   localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE_CYCLES);

   typedef enum logic [1:0] {
      ST_HALT  = 2'b00,
      ST_RUN   = 2'b01,
      ST_STEP  = 2'b10,
      ST_BREAK = 2'b11
   } state_t;

   state_t state_q, state_nxt;
   logic   halt_pend_q, halt_pend_nxt;

   // bit 0 = run button, bit 1 = step button
   logic [1:0]      btn_raw;
   logic [1:0]      sync1_q, sync2_q;
   logic [1:0]      level_q, level_d1_q;
   logic [DB_W-1:0] db_cnt_q [2];
   logic [1:0]      press;
   logic            run_press, step_press;
   logic            bp_hit;

   assign btn_raw = {btn_step, btn_run};

   // The counter must reach DB_MAX with the sample still disagreeing before
   // the accepted level flips; any agreeing sample restarts the count.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q    <= '0;
         sync2_q    <= '0;
         level_q    <= '0;
         level_d1_q <= '0;
         for (int i = 0; i < 2; i++) db_cnt_q[i] <= '0;
      end else begin
         sync1_q    <= btn_raw;
         sync2_q    <= sync1_q;
         level_d1_q <= level_q;
         for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] == level_q[i]) begin
               db_cnt_q[i] <= '0;
            end else if (db_cnt_q[i] == DB_MAX) begin
               level_q[i]  <= sync2_q[i];
               db_cnt_q[i] <= '0;
            end else begin
               db_cnt_q[i] <= db_cnt_q[i] + DB_W'(1);
            end
         end
      end
   end

   assign press      = level_q & ~level_d1_q;
   assign run_press  = press[0];
   assign step_press = press[1];
   assign bp_hit     = bp_en && (pc == bp_addr);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_HALT;
         halt_pend_q <= 1'b0;
      end else begin
         state_q     <= state_nxt;
         halt_pend_q <= halt_pend_nxt;
      end
   end

   always_comb begin
      state_nxt     = state_q;
      halt_pend_nxt = 1'b0;
      case (state_q)
         ST_HALT, ST_BREAK: begin
            if (run_press)       state_nxt = ST_RUN;
            else if (step_press) state_nxt = ST_STEP;
         end
         ST_RUN: begin
            if (instr_done) begin
               // breakpoint wins over a pending halt; either way the pend is consumed
               if (bp_hit)                        state_nxt = ST_BREAK;
               else if (halt_pend_q || run_press) state_nxt = ST_HALT;
            end else begin
               halt_pend_nxt = halt_pend_q || run_press;
            end
         end
         ST_STEP: begin
            if (instr_done) state_nxt = ST_HALT;
         end
         default: state_nxt = ST_HALT;
      endcase
   end

   always_comb begin
      cpu_en = 1'b0;
      halted = 1'b0;
      case (state_q)
         ST_RUN, ST_STEP: cpu_en = 1'b1;
         default:         halted = 1'b1;
      endcase
   end

   assign state = state_q;

   always_ff @(posedge clk) begin
      if (rst)                      retired <= '0;
      else if (cpu_en && instr_done) retired <= retired + CNT_WIDTH'(1);
   end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl: table-driven reset/debounce vectors followed by
// hand-written run-halt, single-step, breakpoint and counter-wrap sequences.
module tb_cpu_run_ctrl;

   localparam logic [1:0] S_HALT  = 2'b00;
   localparam logic [1:0] S_RUN   = 2'b01;
   localparam logic [1:0] S_STEP  = 2'b10;
   localparam logic [1:0] S_BREAK = 2'b11;

   logic       clk = 1'b0;
   logic       rst, btn_run, btn_step, bp_en, instr_done;
   logic [7:0] bp_addr, pc;
   logic       cpu_en, halted;
   logic [1:0] state;
   logic [3:0] retired;

   int tests  = 0;
   int failed = 0;
   int en_cycles;

   cpu_run_ctrl #(
      .DEBOUNCE_CYCLES(4),
      .PC_WIDTH(8),
      .CNT_WIDTH(4)
   ) dut (
      .clk(clk),
      .rst(rst),
      .btn_run(btn_run),
      .btn_step(btn_step),
      .bp_en(bp_en),
      .bp_addr(bp_addr),
      .pc(pc),
      .instr_done(instr_done),
      .cpu_en(cpu_en),
      .state(state),
      .halted(halted),
      .retired(retired)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       rst;
      logic       run;
      logic       step;
      logic       done;
      logic [1:0] es;
      logic [3:0] er;
   } vec_t;

   vec_t tbl[$];

   function automatic void add(logic r, logic ru, logic st, logic d, logic [1:0] es, logic [3:0] er);
      vec_t v;
      v.rst = r; v.run = ru; v.step = st; v.done = d; v.es = es; v.er = er;
      tbl.push_back(v);
   endfunction

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_out(input string tag, input logic [1:0] es, input logic [3:0] er);
      chk({tag, ".state"},   16'(state),   16'(es));
      chk({tag, ".cpu_en"},  16'(cpu_en),  16'((es == S_RUN) || (es == S_STEP)));
      chk({tag, ".halted"},  16'(halted),  16'((es == S_HALT) || (es == S_BREAK)));
      chk({tag, ".retired"}, 16'(retired), 16'(er));
   endtask

   // inputs already set by caller; advance one edge and compare away from it
   task automatic cyc(input string tag, input logic [1:0] es, input logic [3:0] er);
      @(posedge clk);
      #1;
      chk_out(tag, es, er);
   endtask

   task automatic idle(input int n, input logic [1:0] es, input logic [3:0] er);
      for (int i = 0; i < n; i++) begin
         rst = 0; btn_run = 0; btn_step = 0; instr_done = 0;
         cyc("idle", es, er);
      end
   endtask

   initial begin
      rst = 1; btn_run = 0; btn_step = 0; bp_en = 0; bp_addr = 8'h00; pc = 8'h00; instr_done = 0;

      // reset, 20 idle cycles with stray instr_done, step glitch, run press
      add(1, 0, 0, 0, S_HALT, 4'd0);
      add(1, 0, 0, 1, S_HALT, 4'd0);
      for (int i = 0; i < 20; i++) add(0, 0, 0, logic'(i % 2), S_HALT, 4'd0);
      for (int i = 0; i < 3; i++)  add(0, 0, 1, 0, S_HALT, 4'd0);
      for (int i = 0; i < 8; i++)  add(0, 0, 0, 0, S_HALT, 4'd0);
      for (int i = 0; i < 10; i++) add(0, 1, 0, 0, (i >= 7) ? S_RUN : S_HALT, 4'd0);
      for (int i = 0; i < 12; i++) add(0, 0, 0, 0, S_RUN, 4'd0);

      foreach (tbl[k]) begin
         rst = tbl[k].rst; btn_run = tbl[k].run; btn_step = tbl[k].step; instr_done = tbl[k].done;
         cyc("tbl", tbl[k].es, tbl[k].er);
      end

      // RUN, instr_done every 3rd cycle; press sampled at n=10, next retire n=11
      for (int n = 0; n < 30; n++) begin
         btn_run    = (n >= 3 && n < 11);
         instr_done = (n % 3 == 2);
         cyc("run_halt", (n >= 11) ? S_HALT : S_RUN, 4'((n >= 11) ? 4 : (n + 1) / 3));
      end

      // single step: cpu_en high 5 cycles, stray retire at m=15 while halted
      en_cycles = 0;
      for (int m = 0; m < 25; m++) begin
         btn_step   = (m < 8);
         instr_done = (m == 12) || (m == 15);
         cyc("step", (m < 7) ? S_HALT : (m < 12) ? S_STEP : S_HALT, (m >= 12) ? 4'd5 : 4'd4);
         if (cpu_en) en_cycles++;
      end
      chk("step.en_cycles", 16'(en_cycles), 16'd5);

      // breakpoint at 0x10 with pc walking 0x0C..0x10
      bp_en = 1; bp_addr = 8'h10;
      for (int n = 0; n < 20; n++) begin
         btn_step   = 0;
         btn_run    = (n < 8);
         pc         = (n < 8) ? 8'h00 : (n <= 12) ? 8'(8'h0C + n - 8) : 8'h10;
         instr_done = (n >= 8 && n <= 12) || (n == 15);
         cyc("bp", (n < 7) ? S_HALT : (n < 12) ? S_RUN : S_BREAK,
             4'((n < 8) ? 5 : (n <= 12) ? 5 + n - 7 : 10));
      end
      chk("bp.pc_at_break", 16'(pc), 16'h10);
      idle(12, S_BREAK, 4'd10);

      // resume, retire at 0x11, then run press coinciding with a breakpoint retire
      for (int n = 0; n < 30; n++) begin
         btn_run    = (n < 8) || (n >= 20 && n < 28);
         instr_done = (n == 9) || (n == 27);
         pc         = (n == 27) ? 8'h10 : 8'h11;
         cyc("resume", (n < 7) ? S_BREAK : (n < 27) ? S_RUN : S_BREAK,
             4'((n < 9) ? 10 : (n < 27) ? 11 : 12));
      end
      idle(12, S_BREAK, 4'd12);

      // counter wrap 15 -> 0, then reset mid-RUN
      bp_en = 0; pc = 8'h20;
      for (int n = 0; n < 20; n++) begin
         btn_run    = (n < 8);
         instr_done = (n == 9) || (n == 11) || (n == 13) || (n == 15);
         rst        = (n == 18);
         cyc("wrap", (n < 7) ? S_BREAK : (n < 18) ? S_RUN : S_HALT,
             4'((n < 9) ? 12 : (n < 11) ? 13 : (n < 13) ? 14 : (n < 15) ? 15 : 0));
         if (n == 13) chk("wrap.at15", 16'(retired), 16'd15);
         if (n == 15) chk("wrap.to0", 16'(retired), 16'd0);
      end
      rst = 0;
      idle(4, S_HALT, 4'd0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
